ram_fill_scheduler: RTL
=======================

Name: ram_fill_scheduler

Overview:
Write-port controller for the 1024x8 cell RAM. It sequences a block fill of a programmable address range with a selected pattern: constant, incrementing, or LFSR pseudo-random. It shares the single RAM write port between that fill engine and an external host writer using alternating priority under contention. It sits between the control logic and the cell RAM write port and replaces the free-running address/data generator as the RAM's write source.

Parameters:
ADDR_W, 10, RAM address width; RAM depth 2**ADDR_W
DATA_W, 8, RAM data width; the LFSR pattern is defined for DATA_W=8 only

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  fill request; sampled only in IDLE
mode  in  2  pattern: 0 constant, 1 incrementing, 2 LFSR, 3 treated as 0
fill_value  in  DATA_W  constant value, increment start value, or LFSR seed
base_addr  in  ADDR_W  first fill address
length  in  ADDR_W+1  number of words to fill, 0..2**ADDR_W
host_we  in  1  host write request
host_addr  in  ADDR_W  host write address
host_data  in  DATA_W  host write data
host_ready  out  1  host write accepted this cycle when host_we=1 (combinational)
busy  out  1  fill in progress
done  out  1  one-cycle pulse at fill completion
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM write address (registered)
ram_data  out  DATA_W  RAM write data (registered)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0.
  - last_grant=FILL, so the host wins the first contention.
- Reset mid-fill aborts the fill immediately. No further writes; no done pulse.
- States: IDLE, FILL.
- IDLE:
  - host_ready=1.
  - host_we=1 -> next edge: ram_we=1, ram_addr=host_addr, ram_data=host_data. Otherwise ram_we=0.
  - start=1 -> next edge:
    - capture base_addr, length, mode, fill_value; idx=0; pattern=fill_value; busy=1; state=FILL.
    - Mode 2 with fill_value=0 seeds the LFSR with 8'h01.
    - A host write in that same cycle is still performed.
- FILL arbitration, every cycle:
  - Host granted iff host_we=1 and last_grant=FILL; otherwise fill granted.
  - host_ready = (state==IDLE) or (last_grant==FILL).
  - A host held off with host_ready=0 must hold host_we, host_addr and host_data until accepted.
  - Continuous host traffic therefore yields exactly alternating host/fill writes.
  - last_grant updates only on contested or fill grants.
- Fill grant, at the edge:
  - ram_we=1; ram_addr=(base+idx) mod 2**ADDR_W, so the address wraps past the top of RAM; ram_data=pattern; idx++.
  - Pattern advance:
    - mode 1: pattern+1 mod 2**DATA_W.
    - mode 2: Fibonacci LFSR, taps 8,6,5,4; shift left, feedback into bit0.
    - mode 0: hold.
- Completion:
  - The edge that registers write number length-1 also sets state=IDLE, busy=0, done=1.
  - done is therefore coincident with the last ram_we, and deasserts the following cycle.
- length=0: the first FILL cycle returns to IDLE with done=1 and performs no fill write. A contested host write is still served normally.
- length=2**ADDR_W: every address is written exactly once.
- start while busy is ignored; captured parameters are stable for the whole fill.
- Write latency: one cycle from grant to ram_we.
- ram_addr and ram_data hold their last values when ram_we=0.

Optional Feature:
Macro FILL_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in FILL -> next edge: state=IDLE, busy=0, done=0, no fill write. A host write granted in that cycle still completes.
  - abort is ignored in IDLE.
- Undefined: no abort port; a fill always runs to completion or reset.

Test Plan:
- Reset mid-fill: start a fill, drop rst_n low for one cycle -> outputs return to reset values immediately; zero ram_we after release; no done.
- Constant fill, host idle: base=0x3FE, length=4, mode=0, fill_value=0xA5 -> four consecutive writes to 0x3FE, 0x3FF, 0x000, 0x001 (wrap), all 0xA5; done pulses with the 4th write; busy high exactly 4 cycles.
- Incrementing fill with continuous host traffic: base=0x100, length=3, mode=1, fill_value=0xFE, host_we held high -> write order host, fill (0x100, 0xFE), host, fill (0x101, 0xFF), host, fill (0x102, 0x00); host_ready toggles 1,0,1,0,1,0.
- LFSR fill with zero seed: mode=2, fill_value=0, length=3 -> data 0x01, 0x02, 0x04. Second run with seed 0x80 -> first two words 0x80, 0x01.
- Degenerate lengths and start handling: length=0 -> done one cycle after entering FILL, no fill ram_we. length=1024 -> 1024 distinct addresses each written once. start pulsed during busy -> ignored.
- FILL_ABORT_EN build: assert abort after 2 fill writes of a length-10 fill -> exactly 2 writes, busy falls, done never asserted, next start is accepted.

Source files
------------

// File: rtl/ram_fill_scheduler.sv
// ram_fill_scheduler
// Write-port controller for the cell RAM. A fill engine writes a programmable
// address range with a constant, incrementing or LFSR pattern, and shares the
// single RAM write port with an external host writer. Under contention the
// grant alternates between host and fill, starting with the host after reset.
//
// Optional feature: define FILL_ABORT_EN to add the 'abort' input, which ends
// a running fill at the next edge without a done pulse.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               fill request, sampled only while idle
//   mode                0 constant, 1 incrementing, 2 LFSR, 3 same as 0
//   fill_value          constant / increment start value / LFSR seed
//   base_addr, length   first address and word count (0..2**ADDR_W)
//   host_we/addr/data   host write request; held until host_ready
//   abort               (FILL_ABORT_EN only) stop the running fill
//   host_ready          host write accepted this cycle when host_we=1
//   busy, done          fill in progress / one-cycle completion pulse
//   ram_we/addr/data    registered RAM write port
module ram_fill_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8   // LFSR taps are defined for 8-bit data only
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
`ifdef FILL_ABORT_EN
  input  logic              abort,
`endif
  output logic              host_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data
);

  typedef enum logic {IDLE, FILL} state_t;
  typedef enum logic {GRANT_HOST, GRANT_FILL} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              done_d;
  logic              abort_req;
  logic              host_grant;

`ifdef FILL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Fibonacci LFSR, taps 8,6,5,4: shift left, feedback enters bit 0.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] p);
    return {p[DATA_W-2:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  assign busy = (state_q == FILL);

  // Next-state, arbitration and write-port decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    len_d        = len_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    pattern_d    = pattern_q;
    we_d         = 1'b0;
    addr_d       = ram_addr;
    data_d       = ram_data;
    done_d       = 1'b0;
    host_grant   = 1'b0;
    host_ready   = (state_q == IDLE) || (last_grant_q == GRANT_FILL);

    case (state_q)
      IDLE: begin
        // Host writes are uncontested here and do not touch last_grant.
        if (host_we) begin
          we_d   = 1'b1;
          addr_d = host_addr;
          data_d = host_data;
        end
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          mode_d  = mode;
          idx_d   = '0;
          state_d = FILL;
          // An all-zero LFSR would lock up, so a zero seed becomes 1.
          if (mode == 2'd2 && fill_value == '0)
            pattern_d = DATA_W'(1);
          else
            pattern_d = fill_value;
        end
      end

      FILL: begin
        host_grant = host_we && (last_grant_q == GRANT_FILL);
        if (host_grant) begin
          we_d         = 1'b1;
          addr_d       = host_addr;
          data_d       = host_data;
          last_grant_d = GRANT_HOST;
        end

        if (abort_req) begin
          state_d = IDLE;
        end else if (len_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!host_grant) begin
          we_d         = 1'b1;
          addr_d       = base_q + idx_q[ADDR_W-1:0];
          data_d       = pattern_q;
          last_grant_d = GRANT_FILL;
          idx_d        = idx_q + (ADDR_W+1)'(1);
          case (mode_q)
            2'd1:    pattern_d = pattern_q + DATA_W'(1);
            2'd2:    pattern_d = lfsr_next(pattern_q);
            default: pattern_d = pattern_q;
          endcase
          // done rides along with the last write of the range.
          if (idx_q == len_q - (ADDR_W+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_FILL;
      base_q       <= '0;
      len_q        <= '0;
      mode_q       <= '0;
      idx_q        <= '0;
      pattern_q    <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      pattern_q    <= pattern_d;
      ram_we       <= we_d;
      ram_addr     <= addr_d;
      ram_data     <= data_d;
      done         <= done_d;
    end
  end

endmodule
